// File: rtl/mips_main_control.sv
// Multicycle main control FSM for the MiniMIPS 16-bit processor.
// Sequences fetch/decode/execute/memory/write-back and drives the datapath strobes.
module mips_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Opcode,
    input  logic       mem_ready,
    output logic [2:0] ALUop,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       BranchNe,
    output logic       halted,
    output logic       illegal
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNE  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXE_R,
        WB_R,
        EXE_I,
        WB_I,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    state_t state;
    logic   illegal_seen;

    // Illegal opcodes are dropped back to FETCH; only the sticky flag remembers them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            illegal_seen <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) state <= DECODE;
                end
                DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW:              state <= MEMADR;
                        OP_R:                      state <= EXE_R;
                        OP_ADDI, OP_ANDI, OP_ORI:  state <= EXE_I;
                        OP_BEQ, OP_BNE:            state <= BRANCH;
                        OP_J:                      state <= JUMP;
                        OP_HALT:                   state <= HALT;
                        default: begin
                            illegal_seen <= 1'b1;
                            state        <= FETCH;
                        end
                    endcase
                end
                MEMADR:  state <= (Opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (mem_ready) state <= MEMWB;
                end
                MEMWR: begin
                    if (mem_ready) state <= FETCH;
                end
                EXE_R:   state <= WB_R;
                EXE_I:   state <= WB_I;
                MEMWB, WB_R, WB_I, BRANCH, JUMP: state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore decode; the FETCH write strobes additionally wait for the memory handshake.
    always_comb begin
        ALUop       = ALU_ADD;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        BranchNe    = 1'b0;
        halted      = 1'b0;
        illegal     = rst_n & illegal_seen;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXE_R: begin
                    ALUSrcA = 1'b1;
                    ALUop   = ALU_RTYPE;
                end
                WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                EXE_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (Opcode)
                        OP_ANDI: ALUop = ALU_AND;
                        OP_ORI:  ALUop = ALU_OR;
                        default: ALUop = ALU_ADD;
                    endcase
                end
                WB_I: begin
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNe    = (Opcode == OP_BNE);
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: randomized instruction stream and stalls
// compared cycle by cycle against a per-instruction schedule built from the opcode rules.
module tb_mips_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Opcode = 4'd0;
    logic       mem_ready = 1'b0;
    logic [2:0] ALUop;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, BranchNe, halted, illegal;
    logic [1:0] ALUSrcB, PCSource;

    mips_main_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
        .ALUop(ALUop), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .BranchNe(BranchNe), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       branch_ne;
        logic       halted;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic       mr;
        logic [3:0] op;
        out_t       exp;
    } step_t;

    localparam int PH_FW = 0, PH_FG = 1, PH_DEC = 2, PH_MADR = 3, PH_MRD = 4, PH_MWB = 5;
    localparam int PH_MWR = 6, PH_EXR = 7, PH_WBR = 8, PH_EXI = 9, PH_WBI = 10;
    localparam int PH_BR = 11, PH_J = 12, PH_HALT = 13;

    step_t sched[$];
    string tags[$];
    logic  model_illegal = 1'b0;
    int    tests = 0;
    int    failures = 0;

    function automatic string phaseName(input int ph);
        case (ph)
            PH_FW:   return "fetch_wait";
            PH_FG:   return "fetch_go";
            PH_DEC:  return "decode";
            PH_MADR: return "memadr";
            PH_MRD:  return "memrd";
            PH_MWB:  return "memwb";
            PH_MWR:  return "memwr";
            PH_EXR:  return "exe_r";
            PH_WBR:  return "wb_r";
            PH_EXI:  return "exe_i";
            PH_WBI:  return "wb_i";
            PH_BR:   return "branch";
            PH_J:    return "jump";
            default: return "halt";
        endcase
    endfunction

    // Expected strobes for each phase of an instruction, straight from the opcode rules.
    function automatic out_t phaseOut(input int ph, input logic [3:0] op, input logic ill);
        out_t e;
        e = '0;
        e.illegal = ill;
        case (ph)
            PH_FW:   begin e.mem_read = 1; e.alu_src_b = 2'b01; end
            PH_FG:   begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1; end
            PH_DEC:  e.alu_src_b = 2'b11;
            PH_MADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            PH_MRD:  begin e.mem_read = 1; e.iord = 1; end
            PH_MWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            PH_MWR:  begin e.mem_write = 1; e.iord = 1; end
            PH_EXR:  begin e.alu_src_a = 1; e.alu_op = 3'b111; end
            PH_WBR:  begin e.reg_write = 1; e.reg_dst = 1; end
            PH_EXI:  begin
                e.alu_src_a = 1;
                e.alu_src_b = 2'b10;
                e.alu_op = (op == 4'd2) ? 3'b010 : (op == 4'd3) ? 3'b011 : 3'b000;
            end
            PH_WBI:  e.reg_write = 1;
            PH_BR:   begin
                e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.branch_ne = (op == 4'd7);
            end
            PH_J:    begin e.pc_write = 1; e.pc_source = 2'b10; end
            default: e.halted = 1;
        endcase
        return e;
    endfunction

    task automatic pushStep(input int ph, input logic mr, input logic [3:0] op);
        step_t s;
        s.mr  = mr;
        s.op  = op;
        s.exp = phaseOut(ph, op, model_illegal);
        sched.push_back(s);
        tags.push_back(phaseName(ph));
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fstall FETCH waits, mstall memory waits, hold_cycles HALT cycles.
    task automatic pushInstr(input logic [3:0] op, input int fstall, input int mstall, input int hold_cycles);
        for (int i = 0; i < fstall; i++) pushStep(PH_FW, 1'b0, 4'($urandom));
        pushStep(PH_FG, 1'b1, 4'($urandom));
        pushStep(PH_DEC, rnd_bit(), op);
        if (op inside {[4'd0:4'd3]}) begin
            pushStep(op == 4'd0 ? PH_EXR : PH_EXI, rnd_bit(), op);
            pushStep(op == 4'd0 ? PH_WBR : PH_WBI, rnd_bit(), op);
        end else if (op == 4'd4 || op == 4'd5) begin
            pushStep(PH_MADR, rnd_bit(), op);
            for (int i = 0; i < mstall; i++) pushStep(op == 4'd4 ? PH_MRD : PH_MWR, 1'b0, op);
            pushStep(op == 4'd4 ? PH_MRD : PH_MWR, 1'b1, op);
            if (op == 4'd4) pushStep(PH_MWB, rnd_bit(), op);
        end else if (op == 4'd6 || op == 4'd7) begin
            pushStep(PH_BR, rnd_bit(), op);
        end else if (op == 4'd8) begin
            pushStep(PH_J, rnd_bit(), op);
        end else if (op == 4'd15) begin
            for (int i = 0; i < hold_cycles; i++) pushStep(PH_HALT, rnd_bit(), op);
        end else begin
            model_illegal = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [3:0] op);
        mem_ready = mr;
        Opcode    = op;
    endtask

    task automatic checkOutput(input string tag, input out_t exp);
        out_t obs;
        obs = '{ALUop, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, BranchNe, halted, illegal};
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Runs up to n scheduled cycles; entered and left just after a rising edge.
    task automatic runQueue(input int n);
        step_t s;
        string t;
        for (int i = 0; i < n && sched.size() > 0; i++) begin
            s = sched.pop_front();
            t = tags.pop_front();
            applyStimulus(s.mr, s.op);
            @(negedge clk);
            checkOutput(t, s.exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(rnd_bit(), 4'($urandom));
            @(negedge clk);
            checkOutput("reset", '0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        model_illegal = 1'b0;
        sched.delete();
        tags.delete();
    endtask

    initial begin
        logic [3:0] op;
        @(posedge clk);
        #1;
        doReset(2);

        pushInstr(4'd0, 0, 0, 0);
        pushInstr(4'd4, 0, 2, 0);
        pushInstr(4'd5, 1, 1, 0);
        pushInstr(4'd7, 0, 0, 0);
        pushInstr(4'd6, 0, 0, 0);
        pushInstr(4'd8, 2, 0, 0);
        pushInstr(4'd1, 0, 0, 0);
        pushInstr(4'd2, 0, 0, 0);
        pushInstr(4'd3, 0, 0, 0);
        pushInstr(4'd0, 4, 0, 0);
        pushInstr(4'd10, 0, 0, 0);
        pushInstr(4'd0, 0, 0, 0);
        pushInstr(4'd4, 1, 0, 0);
        runQueue(1000);

        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(0, 14));
            pushInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
        end
        runQueue(5000);

        // Reset in the middle of a stalled load.
        pushInstr(4'd4, 0, 3, 0);
        runQueue(4);
        doReset(2);

        pushInstr(4'd5, 0, 0, 0);
        pushInstr(4'd15, 0, 0, 6);
        runQueue(100);
        doReset(1);
        pushInstr(4'd7, 1, 0, 0);
        pushInstr(4'd0, 0, 0, 0);
        runQueue(100);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
